// File: rtl/logic_fold_unit.sv
// logic_fold_unit: folds a frame of operands into one result with a bitwise
// OR, AND, XOR or NOR. The operation is taken from the first beat of a frame.
//
// Ports:
//   clk_i        clock, rising-edge active
//   rst_ni       asynchronous active-low reset
//   op_sel_i     fold operation: 00=OR, 01=AND, 10=XOR, 11=NOR
//   in_valid_i   operand offered
//   in_ready_o   operand may be accepted (low only while a result is pending)
//   in_data_i    operand, BITS wide
//   in_last_i    operand is the final one of its frame
//   out_valid_o  folded result available
//   out_ready_i  consumer takes the result
//   out_data_o   folded result (zero when out_valid_o is low)
//   out_count_o  operands in the frame, saturated at MAX_OPS (zero when idle)
//   out_ovf_o    frame had more than MAX_OPS operands (zero when idle)

module logic_fold_unit #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned MAX_OPS = 16,
    parameter int unsigned CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       op_sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BITS-1:0]  in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BITS-1:0]  out_data_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpOr  = 2'b00,
        OpAnd = 2'b01,
        OpXor = 2'b10,
        OpNor = 2'b11
    } op_e;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OPS);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [BITS-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              accept;

    // NOR accumulates as OR; the inversion is applied only on the output.
    function automatic logic [BITS-1:0] fold(input op_e op, input logic [BITS-1:0] a,
                                             input logic [BITS-1:0] b);
        logic [BITS-1:0] r;
        r = a | b;
        unique case (op)
            OpAnd:   r = a & b;
            OpXor:   r = a ^ b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    assign in_ready_o = (state_q != StDone);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = in_data_i;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    op_d    = op_e'(op_sel_i);
                    state_d = in_last_i ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = fold(op_q, acc_q, in_data_i);
                    // A beat beyond MAX_OPS is still folded but only flags overflow.
                    if (cnt_q == MaxCnt) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last_i) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpOr;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        out_valid_o = (state_q == StDone);
        out_data_o  = '0;
        out_count_o = '0;
        out_ovf_o   = 1'b0;
        if (out_valid_o) begin
            out_data_o  = (op_q == OpNor) ? ~acc_q : acc_q;
            out_count_o = cnt_q;
            out_ovf_o   = ovf_q;
        end
    end

endmodule
